// File: rtl/ex_stage.sv
// ex_stage: execute stage of the RV32IF 5-stage pipeline.
// Resolves MEM/WB forwarding, runs the integer ALU, resolves branches/jumps
// (driving the combinational redirect) and holds the EX/MEM pipeline register.
// Ports:
//   clk, reset (sync, active-high), mem_stall  - clocking / hold
//   ex_*                                       - ID/EX register contents
//   fw_mem_*, fw_wb_*                          - forwarding sources
//   branch, branch_target                      - combinational redirect
//   mem_*                                      - registered EX/MEM state
// Optional macro BRANCH_STATS_EN adds stat_branches / stat_taken counters.
module ex_stage #(
  parameter int unsigned     XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC_LINK = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_immediate,
  input  logic [2:0]      ex_funct_3,
  input  logic [6:0]      ex_funct_7,
  input  logic [6:0]      ex_ex_control,
  input  logic [1:0]      ex_mem_control,
  input  logic [1:0]      ex_wb_control,
  input  logic [4:0]      ex_rd,
  input  logic [4:0]      ex_Rs1,
  input  logic [4:0]      ex_Rs2,
  input  logic [6:0]      ex_opcode,
  input  logic [4:0]      fw_mem_rd,
  input  logic            fw_mem_reg_write,
  input  logic [XLEN-1:0] fw_mem_data,
  input  logic [4:0]      fw_wb_rd,
  input  logic            fw_wb_reg_write,
  input  logic [XLEN-1:0] fw_wb_data,
  output logic            branch,
  output logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_rs2_data,
  output logic [4:0]      mem_rd,
  output logic [2:0]      mem_funct_3,
  output logic [1:0]      mem_mem_control,
  output logic [1:0]      mem_wb_control
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
`endif
);

  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned STAT_W     = 32;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;

  logic ctl_alu_src_imm, ctl_branch, ctl_jal, ctl_jalr, ctl_lui, ctl_auipc, ctl_valid;
  assign {ctl_valid, ctl_auipc, ctl_lui, ctl_jalr, ctl_jal, ctl_branch, ctl_alu_src_imm} = ex_ex_control;

  logic [XLEN-1:0]    fwd_rs1, fwd_rs2, op_a, op_b, alu_res, jalr_sum;
  logic [SHAMT_W-1:0] shamt;
  logic               taken;

  // Forwarding: MEM overrides WB, x0 never forwards.
  always_comb begin
    fwd_rs1 = ex_rs1;
    fwd_rs2 = ex_rs2;
    if (fw_wb_reg_write && (fw_wb_rd != 5'd0) && (fw_wb_rd == ex_Rs1)) fwd_rs1 = fw_wb_data;
    if (fw_wb_reg_write && (fw_wb_rd != 5'd0) && (fw_wb_rd == ex_Rs2)) fwd_rs2 = fw_wb_data;
    if (fw_mem_reg_write && (fw_mem_rd != 5'd0) && (fw_mem_rd == ex_Rs1)) fwd_rs1 = fw_mem_data;
    if (fw_mem_reg_write && (fw_mem_rd != 5'd0) && (fw_mem_rd == ex_Rs2)) fwd_rs2 = fw_mem_data;
  end

  // Operand selection and ALU; non-arithmetic opcodes compute an ADD.
  always_comb begin
    op_a = fwd_rs1;
    if (ctl_auipc || ctl_jal) op_a = ex_pc;
    if (ctl_lui)              op_a = '0;
    op_b  = ctl_alu_src_imm ? ex_immediate : fwd_rs2;
    shamt = op_b[SHAMT_W-1:0];
    alu_res = op_a + op_b;
    if ((ex_opcode == OPC_OP) || (ex_opcode == OPC_OP_IMM)) begin
      case (ex_funct_3)
        3'b000: if (ex_funct_7[5] && (ex_opcode == OPC_OP)) alu_res = op_a - op_b;
        3'b001: alu_res = op_a << shamt;
        3'b010: alu_res = XLEN'($signed(op_a) < $signed(op_b));
        3'b011: alu_res = XLEN'(op_a < op_b);
        3'b100: alu_res = op_a ^ op_b;
        3'b101: alu_res = ex_funct_7[5] ? $unsigned($signed(op_a) >>> shamt) : (op_a >> shamt);
        3'b110: alu_res = op_a | op_b;
        default: alu_res = op_a & op_b;
      endcase
    end
  end

  // Branch condition and redirect target.
  always_comb begin
    case (ex_funct_3)
      3'b000:  taken = (fwd_rs1 == fwd_rs2);
      3'b001:  taken = (fwd_rs1 != fwd_rs2);
      3'b100:  taken = ($signed(fwd_rs1) < $signed(fwd_rs2));
      3'b101:  taken = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      3'b110:  taken = (fwd_rs1 < fwd_rs2);
      3'b111:  taken = (fwd_rs1 >= fwd_rs2);
      default: taken = 1'b0;
    endcase
    jalr_sum      = fwd_rs1 + ex_immediate;
    branch_target = '0;
    if (ctl_branch || ctl_jal) branch_target = ex_pc + ex_immediate;
    else if (ctl_jalr)         branch_target = {jalr_sum[XLEN-1:1], 1'b0};
  end

  assign branch = ctl_valid & ~mem_stall & ~reset & ((ctl_branch & taken) | ctl_jal | ctl_jalr);

  logic [XLEN-1:0] mem_alu_result_q, mem_alu_result_d, mem_rs2_data_q, mem_rs2_data_d;
  logic [4:0]      mem_rd_q, mem_rd_d;
  logic [2:0]      mem_funct_3_q, mem_funct_3_d;
  logic [1:0]      mem_mem_control_q, mem_mem_control_d, mem_wb_control_q, mem_wb_control_d;

  // EX/MEM next state: stall holds everything, bubbles only clear control.
  always_comb begin
    mem_alu_result_d  = mem_alu_result_q;
    mem_rs2_data_d    = mem_rs2_data_q;
    mem_rd_d          = mem_rd_q;
    mem_funct_3_d     = mem_funct_3_q;
    mem_mem_control_d = mem_mem_control_q;
    mem_wb_control_d  = mem_wb_control_q;
    if (!mem_stall) begin
      mem_mem_control_d = '0;
      mem_wb_control_d  = '0;
      if (ctl_valid) begin
        mem_alu_result_d  = (ctl_jal || ctl_jalr) ? (ex_pc + XLEN'(4)) : alu_res;
        mem_rs2_data_d    = fwd_rs2;
        mem_rd_d          = ex_rd;
        mem_funct_3_d     = ex_funct_3;
        mem_mem_control_d = ex_mem_control;
        mem_wb_control_d  = ex_wb_control;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_alu_result_q  <= RESET_PC_LINK;
      mem_rs2_data_q    <= '0;
      mem_rd_q          <= '0;
      mem_funct_3_q     <= '0;
      mem_mem_control_q <= '0;
      mem_wb_control_q  <= '0;
    end else begin
      mem_alu_result_q  <= mem_alu_result_d;
      mem_rs2_data_q    <= mem_rs2_data_d;
      mem_rd_q          <= mem_rd_d;
      mem_funct_3_q     <= mem_funct_3_d;
      mem_mem_control_q <= mem_mem_control_d;
      mem_wb_control_q  <= mem_wb_control_d;
    end
  end

  assign mem_alu_result  = mem_alu_result_q;
  assign mem_rs2_data    = mem_rs2_data_q;
  assign mem_rd          = mem_rd_q;
  assign mem_funct_3     = mem_funct_3_q;
  assign mem_mem_control = mem_mem_control_q;
  assign mem_wb_control  = mem_wb_control_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches_q, stat_branches_d, stat_taken_q, stat_taken_d;

  // Control-transfer counters, frozen while the memory stage stalls.
  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_taken_d    = stat_taken_q;
    if (!mem_stall) begin
      if (ctl_valid && (ctl_branch || ctl_jal || ctl_jalr)) stat_branches_d = stat_branches_q + STAT_W'(1);
      if (branch) stat_taken_d = stat_taken_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_taken_q    <= stat_taken_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
`endif

  // Bits of the inputs the datapath does not consume.
  logic unused_bits;
  assign unused_bits = ^{ex_funct_7[6], ex_funct_7[4:0], jalr_sum[0]};

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage with a behavioural model.
module tb_ex_stage;

  localparam logic [31:0] RST_LINK = 32'h0;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_stall;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_immediate;
  logic [2:0]  ex_funct_3;
  logic [6:0]  ex_funct_7, ex_ex_control, ex_opcode;
  logic [1:0]  ex_mem_control, ex_wb_control;
  logic [4:0]  ex_rd, ex_Rs1, ex_Rs2, fw_mem_rd, fw_wb_rd;
  logic        fw_mem_reg_write, fw_wb_reg_write;
  logic [31:0] fw_mem_data, fw_wb_data;
  logic        branch;
  logic [31:0] branch_target, mem_alu_result, mem_rs2_data;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct_3;
  logic [1:0]  mem_mem_control, mem_wb_control;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif

  ex_stage #(.XLEN(32), .RESET_PC_LINK(RST_LINK)) dut (
    .clk(clk), .reset(reset), .mem_stall(mem_stall), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_immediate(ex_immediate), .ex_funct_3(ex_funct_3),
    .ex_funct_7(ex_funct_7), .ex_ex_control(ex_ex_control), .ex_mem_control(ex_mem_control),
    .ex_wb_control(ex_wb_control), .ex_rd(ex_rd), .ex_Rs1(ex_Rs1), .ex_Rs2(ex_Rs2),
    .ex_opcode(ex_opcode), .fw_mem_rd(fw_mem_rd), .fw_mem_reg_write(fw_mem_reg_write),
    .fw_mem_data(fw_mem_data), .fw_wb_rd(fw_wb_rd), .fw_wb_reg_write(fw_wb_reg_write),
    .fw_wb_data(fw_wb_data), .branch(branch), .branch_target(branch_target),
    .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data), .mem_rd(mem_rd),
    .mem_funct_3(mem_funct_3), .mem_mem_control(mem_mem_control), .mem_wb_control(mem_wb_control)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken)
`endif
  );

  int n_vec = 0, n_chk = 0, n_err = 0;

  // Model state: expected EX/MEM contents and counters.
  logic [31:0] e_alu, e_rs2, e_sb, e_st, exp_target, obs_target;
  logic [4:0]  e_rd;
  logic [2:0]  e_f3;
  logic [1:0]  e_memc, e_wbc;
  logic        exp_branch, obs_branch;

  wire [75:0] exmem_obs = {mem_alu_result, mem_rs2_data, mem_rd, mem_funct_3, mem_mem_control, mem_wb_control};
  wire [75:0] exmem_exp = {e_alu, e_rs2, e_rd, e_f3, e_memc, e_wbc};

  function automatic logic [31:0] fwd_val(input logic [4:0] idx, input logic [31:0] rf);
    if (fw_mem_reg_write && fw_mem_rd != 5'd0 && fw_mem_rd == idx) return fw_mem_data;
    if (fw_wb_reg_write && fw_wb_rd != 5'd0 && fw_wb_rd == idx) return fw_wb_data;
    return rf;
  endfunction

  // Behavioural model of one cycle, evaluated from the current inputs.
  task automatic model_step();
    logic [31:0] a, b, r1, r2, res;
    logic vld, br, jl, jr, tk;
    int unsigned sh;
    vld = ex_ex_control[6]; br = ex_ex_control[1]; jl = ex_ex_control[2]; jr = ex_ex_control[3];
    r1 = fwd_val(ex_Rs1, ex_rs1);
    r2 = fwd_val(ex_Rs2, ex_rs2);
    a = ex_ex_control[4] ? 32'd0 : ((ex_ex_control[5] || jl) ? ex_pc : r1);
    b = ex_ex_control[0] ? ex_immediate : r2;
    sh = b % 32;
    res = a + b;
    if (ex_opcode == OP_R || ex_opcode == OP_I) begin
      case (ex_funct_3)
        3'd0: if (ex_funct_7[5] && ex_opcode == OP_R) res = a - b;
        3'd1: res = 32'(longint'(a) * (longint'(1) << sh));
        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: res = ex_funct_7[5] ? 32'($signed(a) >>> sh) : 32'(a / (64'd1 << sh));
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end
    if (jl || jr) res = ex_pc + 32'd4;
    case (ex_funct_3)
      3'd0: tk = (r1 == r2);
      3'd1: tk = (r1 != r2);
      3'd4: tk = ($signed(r1) < $signed(r2));
      3'd5: tk = !($signed(r1) < $signed(r2));
      3'd6: tk = (r1 < r2);
      3'd7: tk = !(r1 < r2);
      default: tk = 1'b0;
    endcase
    exp_target = (br || jl) ? ex_pc + ex_immediate : (jr ? ((r1 + ex_immediate) & 32'hFFFF_FFFE) : 32'd0);
    exp_branch = vld && !mem_stall && !reset && ((br && tk) || jl || jr);
    if (reset) begin
      e_alu = RST_LINK; e_rs2 = 0; e_rd = 0; e_f3 = 0; e_memc = 0; e_wbc = 0; e_sb = 0; e_st = 0;
    end else if (!mem_stall) begin
      if (vld && (br || jl || jr)) e_sb = e_sb + 1;
      if (exp_branch) e_st = e_st + 1;
      e_memc = 0; e_wbc = 0;
      if (vld) begin
        e_alu = res; e_rs2 = r2; e_rd = ex_rd; e_f3 = ex_funct_3;
        e_memc = ex_mem_control; e_wbc = ex_wb_control;
      end
    end
  endtask

  // One clock: model, sample combinational outputs mid-cycle, cross the edge.
  task automatic step();
    model_step();
    @(negedge clk);
    obs_branch = branch;
    obs_target = branch_target;
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  // Minimal decoder producing the control bundle for an opcode.
  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    logic br, jl, jr;
    br = (opc == OP_BR); jl = (opc == OP_JAL); jr = (opc == OP_JALR);
    ex_opcode = opc; ex_funct_3 = f3; ex_funct_7 = f7;
    ex_ex_control = {1'b1, opc == OP_AUIPC, opc == OP_LUI, jr, jl, br, !(opc == OP_R || br)};
    ex_mem_control = (opc == OP_LD) ? 2'b01 : ((opc == OP_ST) ? 2'b10 : 2'b00);
    ex_wb_control = (opc == OP_LD) ? 2'b11 : ((opc == OP_ST || br) ? 2'b00 : 2'b01);
  endtask

  task automatic clear_fw();
    fw_mem_rd = 0; fw_mem_reg_write = 0; fw_mem_data = 0;
    fw_wb_rd = 0; fw_wb_reg_write = 0; fw_wb_data = 0;
  endtask

  task automatic test_reset();
    reset = 1; mem_stall = 0; clear_fw();
    set_op(OP_JAL, 3'd0, 7'd0);
    ex_pc = 32'h500; ex_immediate = 32'h40; ex_rd = 5'd3; ex_rs1 = 32'h1234; ex_rs2 = 32'h5678;
    step();
    n_chk++; if (exmem_obs !== {RST_LINK, 44'd0}) begin n_err++; $display("FAIL reset_exmem: got %h, expected %h", exmem_obs, {RST_LINK, 44'd0}); end
    n_chk++; if (obs_branch !== 1'b0) begin n_err++; $display("FAIL reset_branch: got %b, expected 0", obs_branch); end
    reset = 0;
  endtask

  task automatic test_forwarding();
    set_op(OP_R, 3'd0, 7'd0);
    ex_rd = 6; ex_Rs1 = 5; ex_Rs2 = 0; ex_rs1 = 32'hAAAA; ex_rs2 = 0;
    fw_mem_rd = 5; fw_mem_reg_write = 1; fw_mem_data = 32'h10;
    fw_wb_rd = 5; fw_wb_reg_write = 1; fw_wb_data = 32'h20;
    step();
    n_chk++; if (mem_alu_result !== 32'h10) begin n_err++; $display("FAIL fwd_mem_priority: got %h, expected 00000010", mem_alu_result); end
    n_chk++; if ({mem_rd, mem_wb_control} !== {5'd6, 2'b01}) begin n_err++; $display("FAIL fwd_rd_wb: got %h, expected %h", {mem_rd, mem_wb_control}, {5'd6, 2'b01}); end
    ex_Rs1 = 0; ex_rs1 = 32'h7; fw_mem_rd = 0; fw_wb_rd = 0; fw_mem_data = 32'hDEAD; fw_wb_data = 32'hBEEF;
    step();
    n_chk++; if (mem_alu_result !== 32'h7) begin n_err++; $display("FAIL fwd_x0: got %h, expected 00000007", mem_alu_result); end
    ex_Rs1 = 5; fw_mem_rd = 3; fw_mem_data = 32'h10; fw_wb_rd = 5; fw_wb_data = 32'h20;
    step();
    n_chk++; if (mem_alu_result !== 32'h20) begin n_err++; $display("FAIL fwd_wb: got %h, expected 00000020", mem_alu_result); end
    set_op(OP_ST, 3'd2, 7'd0);
    ex_Rs1 = 2; ex_rs1 = 32'h1000; ex_immediate = 8; ex_Rs2 = 5; ex_rs2 = 32'h999;
    step();
    n_chk++; if (exmem_obs !== {32'h1008, 32'h20, 5'd6, 3'd2, 2'b10, 2'b00}) begin n_err++;
      $display("FAIL fwd_store: got %h, expected %h", exmem_obs, {32'h1008, 32'h20, 5'd6, 3'd2, 2'b10, 2'b00}); end
  endtask

  task automatic test_branch();
    clear_fw();
    set_op(OP_BR, 3'b100, 7'd0);
    ex_Rs1 = 1; ex_Rs2 = 2; ex_rs1 = 32'hFFFF_FFFF; ex_rs2 = 32'h1; ex_pc = 32'h100; ex_immediate = 32'h20;
    step();
    n_chk++; if ({obs_branch, obs_target} !== {1'b1, 32'h120}) begin n_err++; $display("FAIL blt_taken: got %h, expected %h", {obs_branch, obs_target}, {1'b1, 32'h120}); end
    set_op(OP_BR, 3'b110, 7'd0);
    step();
    n_chk++; if (obs_branch !== 1'b0) begin n_err++; $display("FAIL bltu_not_taken: got %b, expected 0", obs_branch); end
  endtask

  task automatic test_jalr();
    set_op(OP_JALR, 3'd0, 7'd0);
    fw_mem_rd = 1; fw_mem_reg_write = 1; fw_mem_data = 32'h203;
    ex_Rs1 = 1; ex_rs1 = 0; ex_immediate = 32'h4; ex_pc = 32'h40; ex_rd = 1;
    step();
    n_chk++; if ({obs_branch, obs_target} !== {1'b1, 32'h206}) begin n_err++; $display("FAIL jalr_redirect: got %h, expected %h", {obs_branch, obs_target}, {1'b1, 32'h206}); end
    n_chk++; if ({mem_alu_result, mem_wb_control} !== {32'h44, 2'b01}) begin n_err++; $display("FAIL jalr_link: got %h, expected %h", {mem_alu_result, mem_wb_control}, {32'h44, 2'b01}); end
  endtask

  task automatic test_stall();
    clear_fw();
    set_op(OP_BR, 3'd0, 7'd0);
    ex_Rs1 = 1; ex_Rs2 = 2; ex_rs1 = 5; ex_rs2 = 5; ex_pc = 32'h200; ex_immediate = 32'h10; ex_rd = 7;
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (obs_branch !== 1'b0) begin n_err++; $display("FAIL stall_branch%0d: got %b, expected 0", i, obs_branch); end
      n_chk++; if ({mem_alu_result, mem_rd, mem_wb_control} !== {32'h44, 5'd1, 2'b01}) begin n_err++;
        $display("FAIL stall_hold%0d: got %h, expected %h", i, {mem_alu_result, mem_rd, mem_wb_control}, {32'h44, 5'd1, 2'b01}); end
    end
    mem_stall = 0;
    step();
    n_chk++; if ({obs_branch, obs_target} !== {1'b1, 32'h210}) begin n_err++; $display("FAIL stall_release: got %h, expected %h", {obs_branch, obs_target}, {1'b1, 32'h210}); end
    n_chk++; if (exmem_obs !== {32'd10, 32'd5, 5'd7, 3'd0, 2'b00, 2'b00}) begin n_err++;
      $display("FAIL stall_load: got %h, expected %h", exmem_obs, {32'd10, 32'd5, 5'd7, 3'd0, 2'b00, 2'b00}); end
    ex_ex_control[6] = 0;
    step();
    n_chk++; if (obs_branch !== 1'b0) begin n_err++; $display("FAIL redirect_once: got %b, expected 0", obs_branch); end
  endtask

  task automatic test_bubble();
    clear_fw();
    set_op(OP_LD, 3'd2, 7'd0);
    ex_Rs1 = 4; ex_Rs2 = 0; ex_rs1 = 32'h300; ex_immediate = 4; ex_rs2 = 32'h55; ex_rd = 9;
    step();
    n_chk++; if (exmem_obs !== {32'h304, 32'h55, 5'd9, 3'd2, 2'b01, 2'b11}) begin n_err++;
      $display("FAIL load: got %h, expected %h", exmem_obs, {32'h304, 32'h55, 5'd9, 3'd2, 2'b01, 2'b11}); end
    ex_ex_control[6] = 0;
    for (int i = 0; i < 4; i++) begin
      ex_rs1 = $urandom; ex_rs2 = $urandom; ex_immediate = $urandom; ex_rd = 5'($urandom);
      step();
      n_chk++; if (exmem_obs !== {32'h304, 32'h55, 5'd9, 3'd2, 2'b00, 2'b00}) begin n_err++;
        $display("FAIL bubble%0d: got %h, expected %h", i, exmem_obs, {32'h304, 32'h55, 5'd9, 3'd2, 2'b00, 2'b00}); end
    end
  endtask

  task automatic test_reset_mid_stall();
    clear_fw();
    reset = 1; step(); reset = 0;
    ex_Rs1 = 1; ex_Rs2 = 2; ex_rs1 = 3; ex_rs2 = 3; ex_pc = 32'h80; ex_immediate = 32'h8;
    set_op(OP_BR, 3'd0, 7'd0); step();
    set_op(OP_BR, 3'd1, 7'd0); step();
    set_op(OP_JAL, 3'd0, 7'd0); step();
    set_op(OP_JALR, 3'd0, 7'd0); step();
`ifdef BRANCH_STATS_EN
    n_chk++; if ({stat_branches, stat_taken} !== {32'd4, 32'd3}) begin n_err++;
      $display("FAIL stats: got %h, expected %h", {stat_branches, stat_taken}, {32'd4, 32'd3}); end
`endif
    mem_stall = 1; reset = 1;
    step();
    n_chk++; if (exmem_obs !== {RST_LINK, 44'd0}) begin n_err++; $display("FAIL reset_in_stall: got %h, expected %h", exmem_obs, {RST_LINK, 44'd0}); end
    n_chk++; if (obs_branch !== 1'b0) begin n_err++; $display("FAIL reset_in_stall_branch: got %b, expected 0", obs_branch); end
`ifdef BRANCH_STATS_EN
    n_chk++; if ({stat_branches, stat_taken} !== 64'd0) begin n_err++; $display("FAIL stats_reset: got %h, expected 0", {stat_branches, stat_taken}); end
`endif
    mem_stall = 0; reset = 0;
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      mem_stall = ($urandom_range(0, 3) == 0);
      set_op(ops[$urandom_range(0, 8)], 3'($urandom), 7'($urandom));
      ex_ex_control[6] = ($urandom_range(0, 4) != 0);
      ex_pc = $urandom & 32'hFFFF_FFFC; ex_immediate = $urandom; ex_rd = 5'($urandom);
      ex_rs1 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      ex_rs2 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : ($urandom_range(0, 3) == 0 ? ex_rs1 : $urandom);
      ex_Rs1 = 5'($urandom_range(0, 3)); ex_Rs2 = 5'($urandom_range(0, 3));
      fw_mem_rd = 5'($urandom_range(0, 3)); fw_mem_reg_write = 1'($urandom); fw_mem_data = $urandom;
      fw_wb_rd = 5'($urandom_range(0, 3)); fw_wb_reg_write = 1'($urandom); fw_wb_data = $urandom;
      step();
      n_chk++; if (exmem_obs !== exmem_exp) begin n_err++; $display("FAIL rand_exmem%0d: got %h, expected %h", i, exmem_obs, exmem_exp); end
      n_chk++; if ({obs_branch, obs_target} !== {exp_branch, exp_target}) begin n_err++;
        $display("FAIL rand_redirect%0d: got %h, expected %h", i, {obs_branch, obs_target}, {exp_branch, exp_target}); end
`ifdef BRANCH_STATS_EN
      n_chk++; if ({stat_branches, stat_taken} !== {e_sb, e_st}) begin n_err++;
        $display("FAIL rand_stats%0d: got %h, expected %h", i, {stat_branches, stat_taken}, {e_sb, e_st}); end
`endif
    end
    reset = 0; mem_stall = 0;
  endtask

  initial begin
    reset = 0; mem_stall = 0; ex_pc = 0; ex_rs1 = 0; ex_rs2 = 0; ex_immediate = 0;
    ex_funct_3 = 0; ex_funct_7 = 0; ex_ex_control = 0; ex_mem_control = 0; ex_wb_control = 0;
    ex_rd = 0; ex_Rs1 = 0; ex_Rs2 = 0; ex_opcode = 0; clear_fw();
    e_sb = 0; e_st = 0;
    test_reset();
    test_forwarding();
    test_branch();
    test_jalr();
    test_stall();
    test_bubble();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
